// File: rtl/nv_nvdla_sdp_wdma_req_sched.sv
// SDP write-DMA request scheduler: one command packet per command, followed by
// the command's data beats drained from four lane FIFOs in strict round-robin order.
module nv_nvdla_sdp_wdma_req_sched #(
  parameter int AW = 29,
  parameter int SW = 13,
  parameter int DW = 64
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              op_load,
  input  logic              reg2dp_interrupt_ptr,
  input  logic              cmd_pvld,
  output logic              cmd_prdy,
  input  logic [AW+SW:0]    cmd_pd,
  input  logic              dfifo0_rd_pvld,
  output logic              dfifo0_rd_prdy,
  input  logic [DW-1:0]     dfifo0_rd_pd,
  input  logic              dfifo1_rd_pvld,
  output logic              dfifo1_rd_prdy,
  input  logic [DW-1:0]     dfifo1_rd_pd,
  input  logic              dfifo2_rd_pvld,
  output logic              dfifo2_rd_prdy,
  input  logic [DW-1:0]     dfifo2_rd_pd,
  input  logic              dfifo3_rd_pvld,
  output logic              dfifo3_rd_prdy,
  input  logic [DW-1:0]     dfifo3_rd_pd,
  output logic              dma_wr_req_vld,
  input  logic              dma_wr_req_rdy,
  output logic [DW+1:0]     dma_wr_req_pd,
  output logic              dp2reg_done,
  output logic              intr_req_pvld,
  output logic              intr_req_ptr,
  output logic [31:0]       dp2reg_wdma_beat_num
);

  localparam int PAD = DW - AW - SW;

  typedef enum logic {IDLE, DAT} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    lane_ptr_reg, lane_ptr_next;
  logic [SW-1:0] beat_rem_reg, beat_rem_next;
  logic          layer_end_reg, layer_end_next;
  logic          vld_reg, vld_next;
  logic [DW+1:0] pd_reg, pd_next;
  logic          done_reg, done_next;
  logic          intr_ptr_reg, intr_ptr_next;
  logic [31:0]   beat_cnt_reg, beat_cnt_next;

  logic [3:0]    lane_vld;
  logic [3:0]    lane_prdy;
  logic [DW-1:0] lane_pd [4];
  logic          ld, acc, abort, cmd_acc, pop_en, pop, last_beat;
  logic [DW-1:0] cmd_word;

  assign lane_vld  = {dfifo3_rd_pvld, dfifo2_rd_pvld, dfifo1_rd_pvld, dfifo0_rd_pvld};
  assign lane_pd[0] = dfifo0_rd_pd;
  assign lane_pd[1] = dfifo1_rd_pd;
  assign lane_pd[2] = dfifo2_rd_pd;
  assign lane_pd[3] = dfifo3_rd_pd;

  // The output register may take a new packet when empty or being drained this cycle.
  assign ld       = ~vld_reg | dma_wr_req_rdy;
  assign acc      = vld_reg & dma_wr_req_rdy;
  assign abort    = op_load & (state_reg != IDLE);
  // op_load wins over any handshake in the same cycle, so it gates every ready.
  assign cmd_prdy = (state_reg == IDLE) & ld & ~op_load;
  assign cmd_acc  = cmd_pvld & cmd_prdy;
  assign pop_en   = (state_reg == DAT) & ld & ~op_load;
  assign pop      = pop_en & lane_vld[lane_ptr_reg];
  assign last_beat = (beat_rem_reg == '0);
  assign cmd_word = {{PAD{1'b0}}, cmd_pd[AW+SW-1:0]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_prdy[gi] = pop_en & (lane_ptr_reg == 2'(gi));
    end
  endgenerate

  assign dfifo0_rd_prdy = lane_prdy[0];
  assign dfifo1_rd_prdy = lane_prdy[1];
  assign dfifo2_rd_prdy = lane_prdy[2];
  assign dfifo3_rd_prdy = lane_prdy[3];

  always_comb begin
    state_next     = state_reg;
    lane_ptr_next  = lane_ptr_reg;
    beat_rem_next  = beat_rem_reg;
    layer_end_next = layer_end_reg;
    vld_next       = vld_reg;
    pd_next        = pd_reg;

    if (acc) vld_next = 1'b0;

    if (cmd_acc) begin
      vld_next       = 1'b1;
      pd_next        = {1'b0, cmd_pd[AW+SW], cmd_word};
      beat_rem_next  = cmd_pd[AW+SW-1:AW];
      layer_end_next = cmd_pd[AW+SW];
      state_next     = DAT;
    end

    if (pop) begin
      vld_next      = 1'b1;
      pd_next       = {1'b1, last_beat, lane_pd[lane_ptr_reg]};
      lane_ptr_next = lane_ptr_reg + 2'd1;
      beat_rem_next = beat_rem_reg - SW'(1);
      if (last_beat) state_next = IDLE;
    end

    if (op_load) lane_ptr_next = '0;

    if (abort) begin
      state_next = IDLE;
      vld_next   = 1'b0;
    end

    done_next     = acc & pd_reg[DW+1] & pd_reg[DW] & layer_end_reg & ~op_load;
    intr_ptr_next = done_next & reg2dp_interrupt_ptr;

    beat_cnt_next = beat_cnt_reg;
    if (op_load)
      beat_cnt_next = '0;
    else if (acc & pd_reg[DW+1] & ~(&beat_cnt_reg))
      beat_cnt_next = beat_cnt_reg + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_reg     <= IDLE;
      lane_ptr_reg  <= '0;
      beat_rem_reg  <= '0;
      layer_end_reg <= 1'b0;
      vld_reg       <= 1'b0;
      pd_reg        <= '0;
      done_reg      <= 1'b0;
      intr_ptr_reg  <= 1'b0;
      beat_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      lane_ptr_reg  <= lane_ptr_next;
      beat_rem_reg  <= beat_rem_next;
      layer_end_reg <= layer_end_next;
      vld_reg       <= vld_next;
      pd_reg        <= pd_next;
      done_reg      <= done_next;
      intr_ptr_reg  <= intr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
    end
  end

  assign dma_wr_req_vld       = vld_reg;
  assign dma_wr_req_pd        = pd_reg;
  assign dp2reg_done          = done_reg;
  assign intr_req_pvld        = done_reg;
  assign intr_req_ptr         = intr_ptr_reg;
  assign dp2reg_wdma_beat_num = beat_cnt_reg;

endmodule

// File: doc/nv_nvdla_sdp_wdma_req_sched.md
Name: nv_nvdla_sdp_wdma_req_sched

Overview:
- Write-request scheduler for the SDP write DMA.
- Takes one write command at a time and emits one command packet, then drains the four per-lane data FIFOs in strict round-robin lane order as data packets onto the single DMA write-request port.
- Signals layer completion and the interrupt request when the final beat of a layer-end command is accepted downstream.
- Sits between the WDMA command splitter and the DMA write interface.

Parameters:
- AW, 29, command address width (32-byte atom address).
- SW, 13, command size width (beats minus 1).
- DW, 64, lane data width.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
- op_load  in  1  layer start pulse; clears lane pointer and beat counter.
- reg2dp_interrupt_ptr  in  1  interrupt group select, sampled at done.
- cmd_pvld  in  1  command valid.
- cmd_prdy  out  1  command ready.
- cmd_pd  in  AW+SW+1  {layer_end[42], size[41:29], addr[28:0]}.
- dfifoN_rd_pvld  in  1  lane N data valid (N=0..3).
- dfifoN_rd_prdy  out  1  lane N pop (N=0..3).
- dfifoN_rd_pd  in  DW  lane N data (N=0..3).
- dma_wr_req_vld  out  1  request valid.
- dma_wr_req_rdy  in  1  request ready.
- dma_wr_req_pd  out  DW+2  request packet (format below).
- dp2reg_done  out  1  one-cycle layer-done pulse.
- intr_req_pvld  out  1  one-cycle interrupt request.
- intr_req_ptr  out  1  interrupt group, valid with intr_req_pvld.
- dp2reg_wdma_beat_num  out  32  data beats accepted since op_load; saturates at 0xFFFFFFFF.

Behaviour:
- Reset: state IDLE, lane_ptr=0, beat_cnt=0, all outputs 0.
- Output register: dma_wr_req_vld/pd are registered. Load enable ld = !vld | rdy. Once vld=1, pd is held stable until vld&rdy.
- Packet format:
  - Cmd packet: pd[65]=0, pd[64]=layer_end, pd[63:0]={22'b0, size, addr}.
  - Data packet: pd[65]=1, pd[64]=last beat of command, pd[63:0]=lane data.
- FSM IDLE:
  - cmd_prdy = ld.
  - On cmd_pvld&cmd_prdy: load cmd packet, latch size/layer_end, beat_rem=size, go DAT.
  - Cmd packet appears on vld the next cycle.
- FSM DAT:
  - Only lane lane_ptr may be popped: dfifo[lane_ptr]_rd_prdy = ld; all other prdy=0.
  - On pop: load data packet, last=(beat_rem==0), lane_ptr=(lane_ptr+1) mod 4 (wraps 3->0), beat_rem-=1.
  - Popping the last beat returns to IDLE.
  - cmd_prdy=0 throughout DAT.
- Throughput: 1 packet/cycle with rdy held high. A cmd costs exactly size+2 output packets.
- lane_ptr persists across commands within a layer; it is cleared only by op_load or reset.
- Empty lane: stall in DAT with no bubble insertion and no lane skipping.
- Backpressure (rdy=0 while vld=1): no pops, no state change.
- Done: on acceptance (vld&rdy) of a data packet with pd[64]=1 whose command had layer_end=1:
  - dp2reg_done=1 and intr_req_pvld=1 for one cycle, next edge.
  - intr_req_ptr = reg2dp_interrupt_ptr sampled on that edge.
- Beat counter: +1 per accepted data packet, saturating.
- op_load while not IDLE:
  - Abandons the command: state IDLE, vld=0, lane_ptr=0, beat_cnt=0.
  - No done pulse.
  - op_load has priority over every simultaneous handshake.
- op_load in the same cycle as a beat_cnt increment: the result is 0.
- Size arithmetic: SW-bit unsigned. size=0 means 1 beat; size=8191 means 8192 beats.

Test Plan:
- Single cmd, addr=0x123, size=3, layer_end=1, rdy=1, all lanes full -> cmd pkt, then lanes 0,1,2,3 data with pd[64] set only on the 4th beat. dp2reg_done and intr_req_pvld pulse once; beat_num=4.
- Two cmds, size=2 then size=0, no layer_end -> lane order 0,1,2 then 3. No done pulse; lane_ptr=0 after wrap.
- Random rdy toggling (50%) on a size=7 cmd -> pd stable while vld&!rdy. 9 packets total, data in lane order, no duplicates.
- Lane 2 empty for 10 cycles mid-command -> stall with no other lane popped. Resumes at lane 2 when its pvld rises.
- op_load asserted on the 3rd beat of a size=5 cmd -> vld=0 next cycle, IDLE, beat_num=0, no done. Next cmd starts at lane 0.
- size=0 layer_end=1 with reg2dp_interrupt_ptr=1 -> 2 packets. intr_req_ptr=1 together with intr_req_pvld.
